// File: rtl/sdram_wr_pkg.sv
// Shared types and defaults for the SDRAM write-side burst scheduler.
package sdram_wr_pkg;

    localparam int USE_W_DEF  = 10;
    localparam int ADDR_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } wr_state_e;

endpackage

// File: rtl/sdram_wr_addr_gen.sv
// Frame-buffer write address register: advances by the finished burst length
// and wraps back to ADDR_MIN with a one-cycle frame_wrap pulse.
module sdram_wr_addr_gen
    import sdram_wr_pkg::*;
#(
    parameter int          USE_W    = USE_W_DEF,
    parameter int          ADDR_W   = ADDR_W_DEF,
    parameter int unsigned ADDR_MIN = 32'h0,
    parameter int unsigned ADDR_END = 32'h0008_0000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              advance,
    input  logic [USE_W-1:0]  len,
    output logic [ADDR_W-1:0] addr,
    output logic              frame_wrap
);

    localparam logic [ADDR_W-1:0] MIN_A = ADDR_W'(ADDR_MIN);
    localparam logic [ADDR_W:0]   END_W = (ADDR_W+1)'(ADDR_END);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              frame_wrap_q, frame_wrap_d;
    logic [ADDR_W:0]   next_addr;

    always_comb begin
        // One extra bit so a window ending at the top of the address space still compares correctly.
        next_addr    = {1'b0, addr_q} + (ADDR_W+1)'(len);
        addr_d       = addr_q;
        frame_wrap_d = 1'b0;
        if (advance) begin
            if (next_addr >= END_W) begin
                addr_d       = MIN_A;
                frame_wrap_d = 1'b1;
            end else begin
                addr_d = next_addr[ADDR_W-1:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            addr_q       <= MIN_A;
            frame_wrap_q <= 1'b0;
        end else begin
            addr_q       <= addr_d;
            frame_wrap_q <= frame_wrap_d;
        end
    end

    assign addr       = addr_q;
    assign frame_wrap = frame_wrap_q;

endmodule

// File: rtl/sdram_wr_burst_ctrl.sv
// Write-side burst scheduler between the SDRAM write FIFO read port and the SDRAM core.
// Partial-burst flush is built only when WR_FLUSH_EN is defined.
//   state | meaning
//   IDLE  | waiting for a full burst (or flush) worth of FIFO data
//   REQ   | wr_burst_req held high until the core acks
//   BURST | one FIFO pop per wr_beat_req, up to wr_burst_len
//   DONE  | waiting for wr_burst_done, then advancing the address
module sdram_wr_burst_ctrl
    import sdram_wr_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          USE_W     = USE_W_DEF,
    parameter int          ADDR_W    = ADDR_W_DEF,
    parameter int          BURST_LEN = 256,
    parameter int unsigned ADDR_MIN  = 32'h0,
    parameter int unsigned ADDR_END  = 32'h0008_0000
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              enable,
    input  logic              flush,
    input  logic [USE_W-1:0]  fifo_rd_use_num,
    output logic              fifo_rd_req,
    input  logic [DATA_W-1:0] fifo_rd_data,
    output logic              wr_burst_req,
    output logic [ADDR_W-1:0] wr_burst_addr,
    output logic [USE_W-1:0]  wr_burst_len,
    input  logic              wr_burst_ack,
    input  logic              wr_beat_req,
    output logic [DATA_W-1:0] wr_data,
    input  logic              wr_burst_done,
    output logic              busy,
    output logic              frame_wrap
);

    localparam logic [USE_W-1:0] BURST_LEN_W = USE_W'(BURST_LEN);

    wr_state_e         state_q, state_d;
    logic [USE_W-1:0]  beat_cnt_q, beat_cnt_d;
    logic              burst_req_q, burst_req_d;
    logic [USE_W-1:0]  burst_len_q, burst_len_d;
    logic [ADDR_W-1:0] burst_addr_q, burst_addr_d;
    logic              done_seen_q, done_seen_d;
    logic              pop;
    logic              advance;
    logic [ADDR_W-1:0] addr;

`ifndef WR_FLUSH_EN
    logic unused_flush;
    assign unused_flush = flush;
`endif

    always_comb begin
        state_d      = state_q;
        beat_cnt_d   = beat_cnt_q;
        burst_req_d  = burst_req_q;
        burst_len_d  = burst_len_q;
        burst_addr_d = burst_addr_q;
        done_seen_d  = done_seen_q;
        pop          = 1'b0;
        advance      = 1'b0;
        case (state_q)
            IDLE: begin
                done_seen_d = 1'b0;
                if (enable && (fifo_rd_use_num >= BURST_LEN_W)) begin
                    burst_len_d  = BURST_LEN_W;
                    burst_addr_d = addr;
                    burst_req_d  = 1'b1;
                    state_d      = REQ;
                end
`ifdef WR_FLUSH_EN
                else if (enable && flush && (fifo_rd_use_num != '0)) begin
                    burst_len_d  = fifo_rd_use_num;
                    burst_addr_d = addr;
                    burst_req_d  = 1'b1;
                    state_d      = REQ;
                end
`endif
            end
            REQ: begin
                if (wr_burst_ack) begin
                    burst_req_d = 1'b0;
                    beat_cnt_d  = '0;
                    state_d     = BURST;
                end
            end
            BURST: begin
                pop = wr_beat_req && (beat_cnt_q < burst_len_q);
                if (pop) begin
                    beat_cnt_d = beat_cnt_q + 1'b1;
                end
                // The core may report completion before our last pop; remember it for DONE.
                if (wr_burst_done) begin
                    done_seen_d = 1'b1;
                end
                if (beat_cnt_d == burst_len_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (wr_burst_done || done_seen_q) begin
                    advance     = 1'b1;
                    done_seen_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q      <= IDLE;
            beat_cnt_q   <= '0;
            burst_req_q  <= 1'b0;
            burst_len_q  <= '0;
            burst_addr_q <= ADDR_W'(ADDR_MIN);
            done_seen_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            beat_cnt_q   <= beat_cnt_d;
            burst_req_q  <= burst_req_d;
            burst_len_q  <= burst_len_d;
            burst_addr_q <= burst_addr_d;
            done_seen_q  <= done_seen_d;
        end
    end

    sdram_wr_addr_gen #(
        .USE_W    (USE_W),
        .ADDR_W   (ADDR_W),
        .ADDR_MIN (ADDR_MIN),
        .ADDR_END (ADDR_END)
    ) u_addr_gen (
        .clk        (clk),
        .clr        (clr),
        .advance    (advance),
        .len        (burst_len_q),
        .addr       (addr),
        .frame_wrap (frame_wrap)
    );

    assign fifo_rd_req   = pop;
    assign wr_data       = fifo_rd_data;
    assign wr_burst_req  = burst_req_q;
    assign wr_burst_addr = burst_addr_q;
    assign wr_burst_len  = burst_len_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_sdram_wr_burst_ctrl.sv
// Self-checking bench for sdram_wr_burst_ctrl: acts as FIFO and SDRAM core, tracks
// the expected frame address and pop count with a simple burst-level model.
module tb_sdram_wr_burst_ctrl;

    localparam int          DATA_W    = 16;
    localparam int          USE_W     = 10;
    localparam int          ADDR_W    = 24;
    localparam int          BURST_LEN = 256;
    localparam int unsigned ADDR_MIN  = 32'h0;
    localparam int unsigned ADDR_END  = 32'h200;

    logic              clk = 1'b0;
    logic              clr;
    logic              enable;
    logic              flush;
    logic [USE_W-1:0]  fifo_rd_use_num;
    logic              fifo_rd_req;
    logic [DATA_W-1:0] fifo_rd_data;
    logic              wr_burst_req;
    logic [ADDR_W-1:0] wr_burst_addr;
    logic [USE_W-1:0]  wr_burst_len;
    logic              wr_burst_ack;
    logic              wr_beat_req;
    logic [DATA_W-1:0] wr_data;
    logic              wr_burst_done;
    logic              busy;
    logic              frame_wrap;

    int          tests = 0;
    int          fails = 0;
    int          wrap_cnt = 0;
    int          fill = 0;
    int unsigned model_addr = ADDR_MIN;

    sdram_wr_burst_ctrl #(
        .DATA_W    (DATA_W),
        .USE_W     (USE_W),
        .ADDR_W    (ADDR_W),
        .BURST_LEN (BURST_LEN),
        .ADDR_MIN  (ADDR_MIN),
        .ADDR_END  (ADDR_END)
    ) dut (
        .clk             (clk),
        .clr             (clr),
        .enable          (enable),
        .flush           (flush),
        .fifo_rd_use_num (fifo_rd_use_num),
        .fifo_rd_req     (fifo_rd_req),
        .fifo_rd_data    (fifo_rd_data),
        .wr_burst_req    (wr_burst_req),
        .wr_burst_addr   (wr_burst_addr),
        .wr_burst_len    (wr_burst_len),
        .wr_burst_ack    (wr_burst_ack),
        .wr_beat_req     (wr_beat_req),
        .wr_data         (wr_data),
        .wr_burst_done   (wr_burst_done),
        .busy            (busy),
        .frame_wrap      (frame_wrap)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (frame_wrap === 1'b1) wrap_cnt++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, fails=%0d", fails);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_advance(input int len, output bit wrapped);
        int unsigned nxt;
        nxt = model_addr + len;
        wrapped = (nxt >= ADDR_END);
        model_addr = wrapped ? ADDR_MIN : nxt;
    endtask

    task automatic wait_req(input string tag, output bit got);
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            #1;
            got = (wr_burst_req === 1'b1);
        end
        tests++;
        if (!got) begin
            fails++;
            $display("FAIL %s req_timeout: wr_burst_req=%b want 1", tag, wr_burst_req);
        end
    endtask

    // One complete burst as seen from the core side, checked against the model.
    task automatic do_burst(input int ack_dly, input int pct, input int min_cyc,
                            input bit early, input bit drop_en, input int exp_len,
                            input string tag);
        bit got, wrapped, beat, exp_pop, done_sent;
        int pops, pop_err, dat_err, hold_err, k, w0;
        pops = 0; pop_err = 0; dat_err = 0; hold_err = 0; k = 0; done_sent = 1'b0;
        wait_req(tag, got);
        if (!got) return;
        tests++;
        if (wr_burst_addr !== ADDR_W'(model_addr)) begin
            fails++;
            $display("FAIL %s addr: got %0h want %0h", tag, wr_burst_addr, model_addr);
        end
        tests++;
        if (wr_burst_len !== USE_W'(exp_len)) begin
            fails++;
            $display("FAIL %s len: got %0d want %0d", tag, wr_burst_len, exp_len);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s busy_req: got %b want 1", tag, busy);
        end
        for (int i = 0; i < ack_dly; i++) begin
            step();
            #1;
            if (wr_burst_req !== 1'b1 || wr_burst_addr !== ADDR_W'(model_addr) ||
                wr_burst_len !== USE_W'(exp_len)) hold_err++;
        end
        tests++;
        if (hold_err != 0) begin
            fails++;
            $display("FAIL %s req_hold: %0d unstable cycles want 0", tag, hold_err);
        end
        wr_burst_ack = 1'b1;
        step();
        wr_burst_ack = 1'b0;
        if (drop_en) enable = 1'b0;
        #1;
        tests++;
        if (wr_burst_req !== 1'b0) begin
            fails++;
            $display("FAIL %s req_drop: got %b want 0", tag, wr_burst_req);
        end
        w0 = wrap_cnt;
        while ((pops < exp_len || k < min_cyc) && k < 4000) begin
            step();
            fifo_rd_use_num = USE_W'(fill);
            beat = (int'($urandom_range(99)) < pct);
            wr_beat_req = beat;
            fifo_rd_data = DATA_W'($urandom);
            wr_burst_done = early && (pops == exp_len / 2) && !done_sent;
            if (wr_burst_done) done_sent = 1'b1;
            #1;
            exp_pop = beat && (pops < exp_len);
            if (fifo_rd_req !== exp_pop) begin
                if (pop_err == 0)
                    $display("FAIL %s pop@%0d: got %b want %b", tag, pops, fifo_rd_req, exp_pop);
                pop_err++;
            end
            if (wr_data !== fifo_rd_data) dat_err++;
            if (exp_pop) begin
                pops++;
                fill--;
            end
            k++;
        end
        tests++;
        if (pop_err != 0) begin
            fails++;
            $display("FAIL %s pop_seq: %0d wrong cycles want 0", tag, pop_err);
        end
        tests++;
        if (pops != exp_len) begin
            fails++;
            $display("FAIL %s pop_total: got %0d want %0d", tag, pops, exp_len);
        end
        tests++;
        if (dat_err != 0) begin
            fails++;
            $display("FAIL %s wr_data: %0d wrong cycles want 0", tag, dat_err);
        end
        model_advance(exp_len, wrapped);
        if (!early) begin
            step();
            wr_beat_req = 1'b0;
            wr_burst_done = 1'b1;
            #1;
            step();
            wr_burst_done = 1'b0;
            #1;
            tests++;
            if (busy !== 1'b0 || wr_burst_req !== 1'b0) begin
                fails++;
                $display("FAIL %s idle_gap: busy=%b req=%b want 0 0", tag, busy, wr_burst_req);
            end
            tests++;
            if (frame_wrap !== wrapped) begin
                fails++;
                $display("FAIL %s frame_wrap: got %b want %b", tag, frame_wrap, wrapped);
            end
        end else begin
            step();
            wr_beat_req = 1'b0;
            wr_burst_done = 1'b0;
            #1;
        end
        step();
        step();
        #1;
        tests++;
        if (wrap_cnt - w0 != int'(wrapped)) begin
            fails++;
            $display("FAIL %s wrap_count: got %0d want %0d", tag, wrap_cnt - w0, int'(wrapped));
        end
        if (drop_en) begin
            tests++;
            if (busy !== 1'b0) begin
                fails++;
                $display("FAIL %s early_done_busy: got %b want 0", tag, busy);
            end
        end
    endtask

    task automatic test_reset();
        int err;
        err = 0;
        clr = 1'b1; enable = 1'b1; flush = 1'b0;
        fill = 300; fifo_rd_use_num = USE_W'(fill);
        fifo_rd_data = '0; wr_burst_ack = 1'b0; wr_beat_req = 1'b1; wr_burst_done = 1'b0;
        step();
        step();
        #1;
        tests++;
        if (wr_burst_req !== 1'b0) begin fails++; $display("FAIL rst_req: got %b want 0", wr_burst_req); end
        tests++;
        if (wr_burst_len !== '0) begin fails++; $display("FAIL rst_len: got %0d want 0", wr_burst_len); end
        tests++;
        if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b want 0", busy); end
        tests++;
        if (frame_wrap !== 1'b0) begin fails++; $display("FAIL rst_wrap: got %b want 0", frame_wrap); end
        tests++;
        if (fifo_rd_req !== 1'b0) begin fails++; $display("FAIL rst_pop: got %b want 0", fifo_rd_req); end
        clr = 1'b0; enable = 1'b0; wr_beat_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            #1;
            if (wr_burst_req !== 1'b0 || busy !== 1'b0) err++;
        end
        tests++;
        if (err != 0) begin fails++; $display("FAIL disabled_idle: %0d active cycles want 0", err); end
    endtask

    task automatic test_single_burst();
        fill = 256; fifo_rd_use_num = USE_W'(fill); enable = 1'b1;
        do_burst(3, 100, 0, 1'b0, 1'b0, BURST_LEN, "single");
    endtask

    task automatic test_reset_mid_burst();
        bit got;
        int pops;
        pops = 0;
        fill = 300; fifo_rd_use_num = USE_W'(fill); enable = 1'b1;
        wait_req("rst_mid", got);
        if (!got) return;
        tests++;
        if (wr_burst_addr !== ADDR_W'(model_addr)) begin
            fails++;
            $display("FAIL rst_mid addr: got %0h want %0h", wr_burst_addr, model_addr);
        end
        wr_burst_ack = 1'b1;
        step();
        wr_burst_ack = 1'b0;
        for (int i = 0; i < 100; i++) begin
            wr_beat_req = 1'b1;
            step();
            pops++;
        end
        clr = 1'b1;
        step();
        clr = 1'b0; enable = 1'b0;
        #1;
        tests++;
        if (fifo_rd_req !== 1'b0) begin fails++; $display("FAIL rst_mid pop: got %b want 0", fifo_rd_req); end
        tests++;
        if (busy !== 1'b0 || wr_burst_req !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid idle: busy=%b req=%b want 0 0", busy, wr_burst_req);
        end
        tests++;
        if (wr_burst_len !== '0) begin fails++; $display("FAIL rst_mid len: got %0d want 0", wr_burst_len); end
        wr_beat_req = 1'b0;
        model_addr = ADDR_MIN;
        fill = fill - pops - 1;
        fifo_rd_use_num = USE_W'(fill);
    endtask

    task automatic test_wrap_back_to_back();
        fill = 512; fifo_rd_use_num = USE_W'(fill); enable = 1'b1;
        do_burst(1, 100, 0, 1'b0, 1'b0, BURST_LEN, "wrap1");
        do_burst(0, 100, 0, 1'b0, 1'b0, BURST_LEN, "b2b_wrap");
    endtask

    task automatic test_gapped_early_done();
        int err;
        err = 0;
        fill = 600; fifo_rd_use_num = USE_W'(fill); enable = 1'b1;
        do_burst(2, 50, 600, 1'b1, 1'b1, BURST_LEN, "gapped");
        for (int i = 0; i < 20; i++) begin
            step();
            fifo_rd_use_num = USE_W'(fill);
            #1;
            if (wr_burst_req !== 1'b0 || busy !== 1'b0) err++;
        end
        tests++;
        if (err != 0) begin fails++; $display("FAIL enable_low_no_req: %0d active cycles want 0", err); end
    endtask

    task automatic test_flush();
        fill = 40; fifo_rd_use_num = USE_W'(fill); flush = 1'b1; enable = 1'b1;
`ifdef WR_FLUSH_EN
        do_burst(1, 100, 0, 1'b0, 1'b0, 40, "flush");
`else
        begin
            int err;
            err = 0;
            for (int i = 0; i < 30; i++) begin
                step();
                #1;
                if (wr_burst_req !== 1'b0 || busy !== 1'b0) err++;
            end
            tests++;
            if (err != 0) begin fails++; $display("FAIL flush_ignored: %0d active cycles want 0", err); end
        end
`endif
        flush = 1'b0;
    endtask

    task automatic test_random_bursts();
        for (int n = 0; n < 4; n++) begin
            fill = int'($urandom_range(700, 256));
            fifo_rd_use_num = USE_W'(fill);
            flush = 1'($urandom_range(1));
            enable = 1'b1;
            do_burst(int'($urandom_range(5)), int'($urandom_range(100, 30)), 0,
                     1'($urandom_range(1)), 1'b0, BURST_LEN, "rand");
        end
        flush = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_burst();
        test_reset_mid_burst();
        test_wrap_back_to_back();
        test_gapped_early_done();
        test_flush();
        test_random_bursts();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sdram_wr_burst_ctrl.md
Name: sdram_wr_burst_ctrl

Overview:
- Single-clock write-side scheduler sitting directly downstream of the read port of the SDRAM write FIFO.
- Watches the FIFO fill level and requests fixed-length write bursts from the SDRAM core.
- Pops FIFO words per beat, tracks the SDRAM write address, and wraps it inside a frame buffer window.

Parameters:
- DATA_W, 16, FIFO / SDRAM data width.
- USE_W, 10, width of the FIFO fill count and burst length.
- ADDR_W, 24, SDRAM word address width.
- BURST_LEN, 256, words per normal burst. Range 1..2^USE_W-1.
- ADDR_MIN, 0, first word address of the frame window.
- ADDR_END, 24'h080000, exclusive end of the window. (ADDR_END-ADDR_MIN) must be a multiple of BURST_LEN.

Ports:
- clk  in  1  clock (same domain as FIFO rd_clk)
- clr  in  1  synchronous active-high reset
- enable  in  1  permit new bursts
- flush  in  1  request partial-burst drain (used only with WR_FLUSH_EN)
- fifo_rd_use_num  in  USE_W  FIFO read-side fill count
- fifo_rd_req  out  1  FIFO pop
- fifo_rd_data  in  DATA_W  FIFO data, valid one cycle after fifo_rd_req
- wr_burst_req  out  1  burst request to SDRAM core
- wr_burst_addr  out  ADDR_W  burst start address
- wr_burst_len  out  USE_W  beats in burst
- wr_burst_ack  in  1  core accepted request (1-cycle pulse)
- wr_beat_req  in  1  core wants one data word
- wr_data  out  DATA_W  data to core (= fifo_rd_data)
- wr_burst_done  in  1  core finished burst (1-cycle pulse)
- busy  out  1  state != IDLE
- frame_wrap  out  1  1-cycle pulse on address wrap

Behaviour:
- Reset (clr=1 at a clk edge, any state, including mid-burst):
  - state=IDLE, beat_cnt=0, addr=ADDR_MIN.
  - wr_burst_req=0, wr_burst_len=0, frame_wrap=0, busy=0, fifo_rd_req=0.
  - No further pops for the aborted burst.
- wr_data: combinational pass-through of fifo_rd_data. The core samples it the cycle after asserting wr_beat_req.
- IDLE:
  - If enable && fifo_rd_use_num >= BURST_LEN: latch wr_burst_len=BURST_LEN and wr_burst_addr=addr, then go to REQ.
  - Otherwise stay. wr_burst_ack, wr_beat_req and wr_burst_done are ignored.
- REQ:
  - wr_burst_req registered high; address and length held stable.
  - On wr_burst_ack: wr_burst_req=0 next cycle, beat_cnt=0, go to BURST.
  - An ack in the same cycle the request first rises is valid.
- BURST:
  - fifo_rd_req = wr_beat_req && (beat_cnt < wr_burst_len). This is combinational, so the pop occurs the same cycle.
  - beat_cnt increments on each pop.
  - When beat_cnt reaches wr_burst_len, go to DONE. Excess wr_beat_req never pops.
- DONE:
  - Wait for wr_burst_done, then compute next = addr + wr_burst_len.
  - If next >= ADDR_END: addr=ADDR_MIN and pulse frame_wrap for 1 cycle. Else addr=next.
  - Go to IDLE.
  - A wr_burst_done arriving during BURST is held in a sticky flag and consumed on entry to DONE.
- Back-to-back bursts:
  - IDLE re-evaluates the fill count the cycle after DONE exits.
  - Minimum 1 idle cycle between bursts.
- enable deasserted mid-burst: the current burst completes normally and no new burst starts.
- Fill count: fifo_rd_use_num is trusted as non-decreasing during a burst except for own pops. No underflow check beyond the beat_cnt limit.
- Address arithmetic: ADDR_W+1 bits for the compare to avoid overflow.

Optional Feature:
- Macro: WR_FLUSH_EN.
- When defined, in IDLE with enable && flush && 0 < fifo_rd_use_num < BURST_LEN:
  - Latch wr_burst_len = fifo_rd_use_num and run a normal REQ/BURST/DONE sequence.
  - The address advances by that shorter length, with the same wrap rule.
  - A full-burst condition has priority over flush.
- When undefined, the flush port is ignored and bursts are always BURST_LEN.

Decomposition:
- Shared package/header sdram_wr_pkg holds:
  - State encoding IDLE=2'd0, REQ=2'd1, BURST=2'd2, DONE=2'd3.
  - USE_W and ADDR_W defaults.
- One natural sub-module: sdram_wr_addr_gen. It holds the address register, advance-by-len, and the wrap compare with frame_wrap pulse.

Test Plan:
- Reset and idle: clr=1 for 2 cycles with fill=300 → all outputs 0, addr=ADDR_MIN. Release with enable=0 → no wr_burst_req.
- Single burst: fill=256, enable=1, ack after 3 cycles, 256 continuous wr_beat_req, then done → exactly 256 fifo_rd_req pulses, wr_burst_addr=0, next burst addr=0x100.
- Wrap: ADDR_END=0x200, run 2 bursts → second addr=0x100, frame_wrap pulses once after second done, third addr=0.
- Gapped beats plus overrun: wr_beat_req toggling 50% for 600 cycles → pops stop at 256, state reaches DONE, no 257th pop. Early done during BURST is honoured.
- Reset mid-burst: clr at beat 100 → fifo_rd_req=0 next cycle, state IDLE, addr=ADDR_MIN.
- Flush (WR_FLUSH_EN): fill=40, flush=1 → wr_burst_len=40, 40 pops, next addr=previous+40. Without the macro → no request.
